// File: rtl/manchester_pkg.sv
// manchester_pkg: shared helpers for the Manchester symbol timer
// Contents:
//   clog2          ceiling log2, never below 1, used to size phase and counter registers
//   QUAD_DEN etc.  waveform quadrant boundaries as fractions of the symbol (num/QUAD_DEN)
//   clamp          symmetric signed saturation to +/-m
package manchester_pkg;

    localparam int QUAD_DEN = 4;
    localparam int Q1_NUM   = 1;
    localparam int HALF_NUM = 2;
    localparam int Q3_NUM   = 3;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int clamp(input int v, input int m);
        return (v > m) ? m : ((v < -m) ? -m : v);
    endfunction

endpackage

// File: rtl/manchester_lock_det.sv
// manchester_lock_det: declares lock after LOCK_CNT consecutive zero-adjust symbols
// Ports:
//   clk     in   sample clock
//   reset   in   synchronous active-high reset
//   strobe  in   decode-edge strobe (already qualified with enable)
//   zero    in   the adjustment applied on this decode edge was zero
//   lock    out  registered lock indicator
module manchester_lock_det
    import manchester_pkg::*;
#(
    parameter int LOCK_CNT = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    input  logic zero,
    output logic lock
);

    localparam int CW = clog2(LOCK_CNT + 1);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t C_MAX = cnt_t'(LOCK_CNT);
    localparam cnt_t C_ONE = cnt_t'(1);

    if (LOCK_CNT < 1) begin : g_lock_cnt_chk
        $error("LOCK_CNT must be >= 1");
    end

    cnt_t cnt;
    cnt_t cnt_n;

    always_comb cnt_n = !zero ? '0 : (cnt == C_MAX) ? C_MAX : cnt + C_ONE;

    // lock is derived from the next count so it moves on the same edge as the counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            lock <= 1'b0;
        end else if (strobe) begin
            cnt  <= cnt_n;
            lock <= (cnt_n == C_MAX);
        end
    end

endmodule

// File: rtl/manchester_symbol_timer.sv
// manchester_symbol_timer: parametrised symbol timing with clamped per-symbol phase adjust
// Ports:
//   clk      in   sample clock
//   reset    in   synchronous active-high reset, priority over enable
//   enable   in   clock enable; all state holds while low
//   adj      in   signed phase adjust, sampled on the decode edge only (+ extends, - shortens)
//   sync     out  high while the phase sits on the decode point (OSR-1)
//   i_wf     out  in-phase decoding waveform (first half of the symbol)
//   q_wf     out  quadrature decoding waveform (first and last quarter, plus lead cycles)
//   adj_sat  out  last applied adjust was clamped
//   lock     out  timing locked
//   phase    out  debug view of the phase offset by MAX_ADJ
module manchester_symbol_timer
    import manchester_pkg::*;
#(
    parameter int OSR      = 16,
    parameter int ADJ_W    = 3,
    parameter int MAX_ADJ  = 1,
    parameter int LOCK_CNT = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [ADJ_W-1:0]                  adj,
    output logic                              sync,
    output logic                              i_wf,
    output logic                              q_wf,
    output logic                              adj_sat,
    output logic                              lock,
    output logic [clog2(OSR+MAX_ADJ)-1:0]     phase
);

    localparam int PW = clog2(OSR + MAX_ADJ);
    localparam int TW = PW + 1;
    typedef logic signed [TW-1:0] ph_t;
    localparam ph_t P_LAST = ph_t'(OSR - 1);
    localparam ph_t P_MIN  = ph_t'(-MAX_ADJ);
    localparam ph_t P_Q1   = ph_t'(OSR * Q1_NUM / QUAD_DEN);
    localparam ph_t P_HALF = ph_t'(OSR * HALF_NUM / QUAD_DEN);
    localparam ph_t P_Q3   = ph_t'(OSR * Q3_NUM / QUAD_DEN);
    localparam ph_t P_BIAS = ph_t'(MAX_ADJ);
    localparam ph_t P_ONE  = ph_t'(1);
    localparam ph_t P_ZERO = '0;

    if (OSR % 4 != 0 || OSR < 8) begin : g_osr_chk
        $error("OSR must be a multiple of 4 and >= 8");
    end
    if (MAX_ADJ < 1 || MAX_ADJ >= OSR / 4) begin : g_max_adj_chk
        $error("MAX_ADJ must be in 1 .. OSR/4-1");
    end
    if (2 ** (ADJ_W - 1) <= MAX_ADJ) begin : g_adj_w_chk
        $error("ADJ_W too narrow to express MAX_ADJ");
    end

    // one extra bit over the debug width so p can go negative during lead extension
    ph_t  p;
    int   adj_i;
    int   a_eff;
    logic adj_clamped;
    logic adj_zero;
    logic in_range;
    logic dec;

    always_comb begin
        adj_i       = int'($signed(adj));
        a_eff       = clamp(adj_i, MAX_ADJ);
        adj_clamped = (a_eff != adj_i);
        adj_zero    = (a_eff == 0);
        in_range    = (p >= P_MIN) && (p <= P_LAST);
        sync        = (p == P_LAST);
        i_wf        = (p >= P_ZERO) && (p < P_HALF);
        q_wf        = (p < P_Q1) || (p >= P_Q3);
        phase       = PW'(p + P_BIAS);
        dec         = enable && sync;
    end

    // loading -a_eff on the decode edge makes the next symbol OSR + a_eff cycles long
    always_ff @(posedge clk) begin
        if (reset) begin
            p       <= P_ZERO;
            adj_sat <= 1'b0;
        end else if (enable) begin
            p <= !in_range ? P_ZERO : sync ? ph_t'(-a_eff) : p + P_ONE;
            if (sync) adj_sat <= adj_clamped;
        end
    end

    manchester_lock_det #(
        .LOCK_CNT(LOCK_CNT)
    ) u_lock_det (
        .clk   (clk),
        .reset (reset),
        .strobe(dec),
        .zero  (adj_zero),
        .lock  (lock)
    );

endmodule

// File: tb/tb_manchester_symbol_timer.sv
// tb_manchester_symbol_timer: symbol-level scoreboard for the Manchester symbol timer
module tb_manchester_symbol_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] adj = 3'd0;
    logic       sync, i_wf, q_wf, adj_sat, lock;
    logic [4:0] phase;
    logic       sync1, i1, q1, sat1, lock1;
    logic [4:0] phase1;

    always #5 clk = ~clk;

    manchester_symbol_timer #(.OSR(16), .ADJ_W(3), .MAX_ADJ(1), .LOCK_CNT(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .adj(adj),
        .sync(sync), .i_wf(i_wf), .q_wf(q_wf), .adj_sat(adj_sat), .lock(lock), .phase(phase)
    );

    manchester_symbol_timer #(.OSR(16), .ADJ_W(3), .MAX_ADJ(1), .LOCK_CNT(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .adj(adj),
        .sync(sync1), .i_wf(i1), .q_wf(q1), .adj_sat(sat1), .lock(lock1), .phase(phase1)
    );

    typedef struct {
        int len;
        int ic;
        int qc;
        int ph;
        int sat;
        int lk;
        int lk1;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   toggle = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // hand-computed symbol shapes for OSR=16 after an applied adjust of 0, +1 or -1
    function automatic exp_t shp(input int a, input int sat, input int lk, input int lk1);
        exp_t e;
        if (a > 0) begin
            e.len = 17; e.ic = 8; e.qc = 9; e.ph = 0;
        end else if (a < 0) begin
            e.len = 15; e.ic = 7; e.qc = 7; e.ph = 2;
        end else begin
            e.len = 16; e.ic = 8; e.qc = 8; e.ph = 1;
        end
        e.sat = sat;
        e.lk  = lk;
        e.lk1 = lk1;
        return e;
    endfunction

    // monitor: accumulates each symbol over enabled cycles and scores it at sync
    int   cyc = 0;
    int   ic = 0;
    int   qc = 0;
    int   ph0 = 0;
    bit   prev_rst = 1'b1;
    exp_t e;

    always @(negedge clk) begin
        if (reset) begin
            cyc = 0; ic = 0; qc = 0;
        end else begin
            if (prev_rst) begin
                chk("rst_sync", int'(sync), 0);
                chk("rst_i_wf", int'(i_wf), 1);
                chk("rst_q_wf", int'(q_wf), 1);
                chk("rst_adj_sat", int'(adj_sat), 0);
                chk("rst_lock", int'(lock), 0);
                chk("rst_lock1", int'(lock1), 0);
                chk("rst_phase", int'(phase), 1);
            end
            if (enable) begin
                if (cyc == 0) ph0 = int'(phase);
                cyc++;
                ic += int'(i_wf);
                qc += int'(q_wf);
                if (sync) begin
                    if (exp_q.size() == 0) chk("unexpected_sync", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("sym_len", cyc, e.len);
                        chk("i_high", ic, e.ic);
                        chk("q_high", qc, e.qc);
                        chk("first_phase", ph0, e.ph);
                        chk("adj_sat", int'(adj_sat), e.sat);
                        chk("lock", int'(lock), e.lk);
                        chk("lock1", int'(lock1), e.lk1);
                    end
                    cyc = 0; ic = 0; qc = 0;
                end
            end
        end
        prev_rst = reset;
    end

    // one enabled cycle, optionally preceded by disabled cycles; adj is junk except on the decode cycle
    task automatic step(input logic [2:0] a, input bit last);
        if (toggle) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
                enable = 1'b0;
                adj = 3'($urandom);
            end
        end
        @(posedge clk); #1;
        enable = 1'b1;
        adj = last ? a : 3'($urandom);
    endtask

    // drive one symbol of l enabled cycles ending with adj a; nx describes the following symbol
    task automatic sym(input int l, input logic [2:0] a, input bit push, input exp_t nx);
        if (push) exp_q.push_back(nx);
        repeat (l - 1) step(3'd0, 1'b0);
        step(a, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        enable = 1'b1;
        adj = 3'($urandom);
        @(posedge clk); #1;
        reset = 1'b0;
        enable = 1'b0;
    endtask

    initial begin
        exp_q.push_back(shp(0, 0, 0, 0));
        @(posedge clk); #1;
        reset = 1'b0;
        sym(16, 3'd0, 1'b1, shp(0, 0, 0, 1));
        sym(16, 3'd1, 1'b1, shp(1, 0, 0, 0));
        sym(17, 3'd7, 1'b1, shp(-1, 0, 0, 0));
        sym(15, 3'd3, 1'b1, shp(1, 1, 0, 0));
        sym(17, 3'd4, 1'b1, shp(-1, 1, 0, 0));
        sym(15, 3'd0, 1'b1, shp(0, 0, 0, 1));
        for (int k = 2; k <= 7; k++) sym(16, 3'd0, 1'b1, shp(0, 0, 0, 1));
        sym(16, 3'd0, 1'b1, shp(0, 0, 1, 1));
        sym(16, 3'd0, 1'b1, shp(0, 0, 1, 1));
        sym(16, 3'd7, 1'b1, shp(-1, 0, 0, 0));
        sym(15, 3'd2, 1'b1, shp(1, 1, 0, 0));
        toggle = 1'b1;
        sym(17, 3'd0, 1'b1, shp(0, 0, 0, 1));
        sym(16, 3'd5, 1'b1, shp(-1, 1, 0, 0));
        sym(15, 3'd3, 1'b1, shp(1, 1, 0, 0));
        repeat (10) step(3'd0, 1'b0);
        exp_q.delete();
        exp_q.push_back(shp(0, 0, 0, 0));
        do_reset();
        for (int k = 1; k <= 7; k++) sym(16, 3'd0, 1'b1, shp(0, 0, 0, 1));
        sym(16, 3'd0, 1'b1, shp(0, 0, 1, 1));
        repeat (9) step(3'd0, 1'b0);
        exp_q.delete();
        exp_q.push_back(shp(0, 0, 0, 0));
        do_reset();
        sym(16, 3'd0, 1'b1, shp(0, 0, 0, 1));
        sym(16, 3'd0, 1'b0, shp(0, 0, 0, 0));
        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
